uart_tx_fifo_drain: RTL

- UART transmitter at the read end of the TX byte FIFO.
- Pops one word at a time from the FIFO and serialises it LSB-first onto the line as start / data / stop.
- Sits between the TX FIFO (whose read data is registered, valid the cycle after a dequeue request) and the top-level tx pin.

---
 rtl/uart_tx_fifo_drain.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
//
// Purpose:
//   UART transmitter sitting on the read side of the TX byte FIFO. It pops one
//   word at a time and sends it LSB-first as start / data / [parity] / stop.
//   The FIFO read data is registered, so it is valid the cycle after the pop.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (>= 2)
//   DATA_BITS     word width (5..9), must match the FIFO
//   STOP_BITS     number of stop bits (1 or 2)
//
// Optional feature:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                      last data bit and the stop period.
//
// Ports:
//   clk               in   system clock, rising edge
//   reset             in   synchronous active-high reset
//   tx_enable         in   allows new frames to start (frame in flight always
//                          completes)
//   fifo_is_empty     in   FIFO empty flag
//   fifo_dequeue      in   FIFO registered read data
//   fifo_req_dequeue  out  one-cycle pop request
//   tx                out  serial line, idle high
//   busy              out  high from the pop request to the end of stop
//   tx_done           out  one-cycle pulse on the last stop-bit cycle
//   o_dbg_state       out  current FSM state (observation only)
//
// Handshake: fifo_req_dequeue is a single-cycle strobe issued only in IDLE when
// tx_enable=1 and fifo_is_empty=0; the FIFO answers with data on fifo_dequeue
// in the following cycle (FETCH), where it is latched unconditionally.
// -----------------------------------------------------------------------------
module uart_tx_fifo_drain #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_enable,
   input  logic                 fifo_is_empty,
   input  logic [DATA_BITS-1:0] fifo_dequeue,
   output logic                 fifo_req_dequeue,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done,
   output logic [2:0]           o_dbg_state
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_PENULT = BAUD_W'(CLKS_PER_BIT - 2);
   localparam logic [BAUD_W-1:0] BAUD_ONE    = BAUD_W'(1);
   localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST   = BIT_W'(STOP_BITS - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE     = BIT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd5,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t               r_state;
   logic [BAUD_W-1:0]    r_baud;
   logic [BIT_W-1:0]     r_bit;     // data bit index, reused as stop-bit index
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_tx;
   logic                 r_done;
`ifdef UART_TX_PARITY_EN
   logic                 r_parity;
`endif

   // The pop must be seen by the FIFO in the same IDLE cycle the condition
   // holds (its data comes back one cycle later), so the request is decoded
   // from the registered state and the live inputs. Reset masks it so no word
   // is popped while the block is being reset.
   logic w_pop;
   assign w_pop = (r_state == S_IDLE) && tx_enable && !fifo_is_empty && !reset;

   assign fifo_req_dequeue = w_pop;
   assign busy             = (r_state != S_IDLE) || w_pop;
   assign tx               = r_tx;
   assign tx_done          = r_done;
   assign o_dbg_state      = r_state;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_tx     <= 1'b1;
         r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_tx   <= 1'b1;
               r_baud <= '0;
               r_bit  <= '0;
               if (w_pop) r_state <= S_FETCH;
            end

            S_FETCH: begin
               r_shift  <= fifo_dequeue;
`ifdef UART_TX_PARITY_EN
               r_parity <= ^fifo_dequeue;
`endif
               r_tx     <= 1'b0;       // start bit appears on the next edge
               r_baud   <= '0;
               r_state  <= S_START;
            end

            S_START: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud + BAUD_ONE;
               end
            end

            S_DATA: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud <= '0;
                  if (r_bit == BIT_LAST) begin
                     r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
                     r_tx    <= r_parity;
                     r_state <= S_PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_bit   <= r_bit + BIT_ONE;
                     r_tx    <= r_shift[0];
                     r_shift <= r_shift >> 1;
                  end
               end else begin
                  r_baud <= r_baud + BAUD_ONE;
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (r_baud == BAUD_LAST) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end else begin
                  r_baud <= r_baud + BAUD_ONE;
               end
            end
`endif

            S_STOP: begin
               r_tx <= 1'b1;
               // tx_done is registered, so it is raised one cycle ahead of the
               // final stop cycle; CLKS_PER_BIT >= 2 guarantees that cycle exists.
               if (r_baud == BAUD_PENULT && r_bit == STOP_LAST) r_done <= 1'b1;
               if (r_baud == BAUD_LAST) begin
                  r_baud <= '0;
                  if (r_bit == STOP_LAST) begin
                     r_bit   <= '0;
                     r_state <= S_IDLE;
                  end else begin
                     r_bit <= r_bit + BIT_ONE;
                  end
               end else begin
                  r_baud <= r_baud + BAUD_ONE;
               end
            end

            default: begin
               r_tx    <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
